// File: rtl/ncl_sync_pkg.sv
// Shared types and constants for the NCL-to-synchronous sink.
package ncl_sync_pkg;

  localparam int RAIL1 = 1;
  localparam int RAIL0 = 0;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_WAIT_DATA = 2'b00,
    ST_HOLD      = 2'b01,
    ST_WAIT_NULL = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CLS_PARTIAL = 2'b00,
    CLS_DATA    = 2'b01,
    CLS_NULL    = 2'b10,
    CLS_ILLEGAL = 2'b11
  } cls_t;

endpackage

// File: rtl/ncl_rail_sync.sv
// Two-flop synchronizer, one chain per rail, async active-low clear.
module ncl_rail_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         init_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_sync_sink.sv
// Accepts dual-rail NCL wavefronts, delivers them as a valid/ready binary word
// and drives the NCL completion signal back to the producing stage.
//
// state        | meaning
// WAIT_DATA    | counting identical DATA_COMPLETE samples, dout_comp=0
// HOLD         | word presented on out_data/out_valid, din ignored
// WAIT_NULL    | dout_comp=1, counting NULL_COMPLETE samples
module ncl_sync_sink
  import ncl_sync_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int STABLE = 2
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [2*WIDTH-1:0] din,
  output logic               dout_comp,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  output logic [15:0]        tokens
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

  state_t             state_q, state_d;
  cls_t               cls;
  logic [2*WIDTH-1:0] sync_q, prev_q;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d, ncnt_q, ncnt_d;
  logic [WIDTH-1:0]   cap_word, data_q;
  logic [15:0]        tok_q;
  logic               err_q;
  logic               capture, handshake, null_done;

  ncl_rail_sync #(.W(2*WIDTH)) u_sync (
    .clk    (clk),
    .init_n (init_n),
    .d      (din),
    .q      (sync_q)
  );

  function automatic cls_t classify(input logic [2*WIDTH-1:0] s);
    logic any_ill, all_one, all_zero;
    any_ill  = 1'b0;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[2*i+RAIL1] && s[2*i+RAIL0]) any_ill = 1'b1;
      if (s[2*i+RAIL1] == s[2*i+RAIL0]) all_one = 1'b0;
      if (s[2*i+RAIL1] || s[2*i+RAIL0]) all_zero = 1'b0;
    end
    if (any_ill)       return CLS_ILLEGAL;
    else if (all_one)  return CLS_DATA;
    else if (all_zero) return CLS_NULL;
    else               return CLS_PARTIAL;
  endfunction

  always_comb begin
    cls = classify(sync_q);
    cap_word = '0;
    for (int i = 0; i < WIDTH; i++) cap_word[i] = prev_q[2*i+RAIL1];
  end

  // Counters and event strobes; prev_q holds the sample the data count refers to.
  always_comb begin
    dcnt_d    = '0;
    ncnt_d    = '0;
    capture   = 1'b0;
    handshake = 1'b0;
    null_done = 1'b0;
    case (state_q)
      ST_WAIT_DATA: begin
        if (dcnt_q == STABLE_C) begin
          capture = 1'b1;
        end else if (cls == CLS_DATA) begin
          dcnt_d = (sync_q == prev_q && dcnt_q != '0) ? dcnt_q + CNT_W'(1) : CNT_W'(1);
        end
      end
      ST_HOLD: handshake = out_valid && out_ready;
      ST_WAIT_NULL: begin
        if (cls == CLS_NULL) begin
          if (ncnt_q + CNT_W'(1) == STABLE_C) null_done = 1'b1;
          else                                ncnt_d    = ncnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= ST_WAIT_DATA;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_DATA: if (capture)   state_d = ST_HOLD;
      ST_HOLD:      if (handshake) state_d = ST_WAIT_NULL;
      ST_WAIT_NULL: if (null_done) state_d = ST_WAIT_DATA;
      default:                     state_d = ST_WAIT_DATA;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_HOLD);
    dout_comp = (state_q == ST_WAIT_NULL);
    out_data  = data_q;
    tokens    = tok_q;
    err       = err_q;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dcnt_q <= '0;
      ncnt_q <= '0;
      prev_q <= '0;
      data_q <= '0;
      tok_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      ncnt_q <= ncnt_d;
      prev_q <= sync_q;
      if (cls == CLS_ILLEGAL) err_q <= 1'b1;
      if (capture) begin
        data_q <= cap_word;
        tok_q  <= tok_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ncl_sync_sink.sv
// Randomized directed bench for ncl_sync_sink with a transaction-level model.
module tb_ncl_sync_sink;

  localparam int W = 2;
  localparam int S = 2;

  logic           clk;
  logic           init_n;
  logic [2*W-1:0] din;
  logic           dout_comp;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           err;
  logic [15:0]    tokens;

  int          ncmp;
  int          nerr;
  logic [15:0] exp_tokens;
  logic        exp_err;

  ncl_sync_sink #(.WIDTH(W), .STABLE(S)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .din       (din),
    .dout_comp (dout_comp),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .tokens    (tokens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Binary value -> dual-rail word: bit 1 raises rail1, bit 0 raises rail0.
  function automatic logic [2*W-1:0] encode(input int v);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (((v >> i) & 1) == 1) r[2*i+1] = 1'b1;
      else                     r[2*i]   = 1'b1;
    end
    return r;
  endfunction

  // Keep only the digits selected by mask, the rest NULL.
  function automatic logic [2*W-1:0] keep_digits(input logic [2*W-1:0] w, input int mask);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (((mask >> i) & 1) == 1) begin
        r[2*i+1] = w[2*i+1];
        r[2*i]   = w[2*i];
      end
    return r;
  endfunction

  // One full four-phase token. mode: 0 clean, 1 staggered rails, 2 other DATA glitch first.
  task automatic do_token(input int val, input int mode, input int rdly, input bit null_stagger);
    logic [2*W-1:0] enc;
    int lat;
    int k;
    enc = encode(val);
    out_ready = (rdly == 0);
    if (mode == 1) begin
      k = $urandom_range(1, 3);
      @(negedge clk);
      din = keep_digits(enc, $urandom_range(1, (1 << W) - 2));
      repeat (k - 1) @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      din = encode((val + 1 + $urandom_range(0, (1 << W) - 2)) % (1 << W));
    end
    @(negedge clk);
    din = enc;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat < S + 3) chk("early_valid", {31'b0, out_valid}, 32'd0);
    end while (!out_valid && lat < 50);
    chk("data_latency", lat, S + 3);
    chk("out_data", out_data, val);
    exp_tokens = exp_tokens + 16'd1;
    chk("tokens", tokens, exp_tokens);
    chk("comp_low_hold", dout_comp, 0);
    chk("err", err, exp_err);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, val);
      chk("hold_comp", dout_comp, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("ack_valid_low", out_valid, 0);
    chk("ack_comp_high", dout_comp, 1);
    if (null_stagger) begin
      din = keep_digits(enc, $urandom_range(1, (1 << W) - 2));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      chk("comp_partial_null", dout_comp, 1);
    end
    din = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (dout_comp && lat < 50);
    chk("null_latency", lat, S + 2);
    chk("data_kept", out_data, val);
    chk("valid_idle", out_valid, 0);
  endtask

  initial begin
    int lat;
    ncmp       = 0;
    nerr       = 0;
    exp_tokens = '0;
    exp_err    = 1'b0;
    init_n     = 1'b0;
    din        = '0;
    out_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_comp", dout_comp, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_tokens", tokens, 0);
    init_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic token 2'b10 with ready high
    do_token(2, 0, 0, 1'b0);
    // Staggered rail arrival, then a glitching DATA value before the real one
    do_token(2, 1, 0, 1'b0);
    do_token(1, 2, 0, 1'b1);
    // Consumer stalls for 10 cycles
    do_token(3, 0, 10, 1'b0);

    // Single-cycle ILLEGAL in WAIT_DATA
    @(negedge clk);
    din = 4'b0011;
    @(negedge clk);
    din = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!err && lat < 20);
    exp_err = 1'b1;
    chk("err_latency", lat, 2);
    chk("err_set", err, 1);
    chk("illegal_no_valid", out_valid, 0);
    chk("illegal_no_comp", dout_comp, 0);
    repeat (4) @(negedge clk);
    do_token(0, 0, 0, 1'b0);
    chk("err_sticky", err, 1);

    // Reset pulse while a word is held
    out_ready = 1'b0;
    @(negedge clk);
    din = encode(1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk("pre_rst_latency", lat, S + 3);
    init_n = 1'b0;
    din    = '0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_comp", dout_comp, 0);
    chk("midrst_tokens", tokens, 0);
    chk("midrst_err", err, 0);
    chk("midrst_data", out_data, 0);
    exp_tokens = '0;
    exp_err    = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_no_valid", out_valid, 0);
    do_token(2, 0, 0, 1'b0);

    // Token counter wrap
    @(negedge clk);
    force dut.tok_q = 16'hFFFF;
    #1;
    release dut.tok_q;
    exp_tokens = 16'hFFFF;
    do_token(1, 0, 0, 1'b0);
    chk("wrap_tokens", tokens, 0);
    chk("wrap_err", err, 0);

    // Randomized tokens
    for (int n = 0; n < 30; n++) begin
      do_token($urandom_range(0, (1 << W) - 1), $urandom_range(0, 2),
               ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0,
               $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
